// File: rtl/axil_dual_port_ram.sv
// Dual-port AXI4-Lite slave RAM: two independent AXI-Lite slaves sharing one
// word-organised array `mem` on a single clock. Port B wins same-word byte collisions.
module axil_dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_a_awaddr,
    input  logic [2:0]            s_axil_a_awprot,
    input  logic                  s_axil_a_awvalid,
    output logic                  s_axil_a_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_a_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_a_wstrb,
    input  logic                  s_axil_a_wvalid,
    output logic                  s_axil_a_wready,
    output logic [1:0]            s_axil_a_bresp,
    output logic                  s_axil_a_bvalid,
    input  logic                  s_axil_a_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_a_araddr,
    input  logic [2:0]            s_axil_a_arprot,
    input  logic                  s_axil_a_arvalid,
    output logic                  s_axil_a_arready,
    output logic [DATA_WIDTH-1:0] s_axil_a_rdata,
    output logic [1:0]            s_axil_a_rresp,
    output logic                  s_axil_a_rvalid,
    input  logic                  s_axil_a_rready,

    input  logic [ADDR_WIDTH-1:0] s_axil_b_awaddr,
    input  logic [2:0]            s_axil_b_awprot,
    input  logic                  s_axil_b_awvalid,
    output logic                  s_axil_b_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_b_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_b_wstrb,
    input  logic                  s_axil_b_wvalid,
    output logic                  s_axil_b_wready,
    output logic [1:0]            s_axil_b_bresp,
    output logic                  s_axil_b_bvalid,
    input  logic                  s_axil_b_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_b_araddr,
    input  logic [2:0]            s_axil_b_arprot,
    input  logic                  s_axil_b_arvalid,
    output logic                  s_axil_b_arready,
    output logic [DATA_WIDTH-1:0] s_axil_b_rdata,
    output logic [1:0]            s_axil_b_rresp,
    output logic                  s_axil_b_rvalid,
    input  logic                  s_axil_b_rready
);

    localparam int BYTE_BITS = $clog2(STRB_WIDTH);
    localparam int WORD_AW   = ADDR_WIDTH - BYTE_BITS;
    localparam int DEPTH     = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    logic [WORD_AW-1:0]    a_wr_word, a_rd_word, b_wr_word, b_rd_word;
    logic                  a_wr_en, a_rd_en, b_wr_en, b_rd_en;
    logic [DATA_WIDTH-1:0] a_mask, b_mask, a_merged, b_base, b_merged;

    assign a_wr_word = s_axil_a_awaddr[ADDR_WIDTH-1:BYTE_BITS];
    assign a_rd_word = s_axil_a_araddr[ADDR_WIDTH-1:BYTE_BITS];
    assign b_wr_word = s_axil_b_awaddr[ADDR_WIDTH-1:BYTE_BITS];
    assign b_rd_word = s_axil_b_araddr[ADDR_WIDTH-1:BYTE_BITS];

    // The !awready / !arready terms force each transaction to take at least two cycles.
    assign a_wr_en = s_axil_a_awvalid & s_axil_a_wvalid & ~s_axil_a_awready
                   & (~s_axil_a_bvalid | s_axil_a_bready) & ~rst;
    assign b_wr_en = s_axil_b_awvalid & s_axil_b_wvalid & ~s_axil_b_awready
                   & (~s_axil_b_bvalid | s_axil_b_bready) & ~rst;
    assign a_rd_en = s_axil_a_arvalid & ~s_axil_a_arready
                   & (~s_axil_a_rvalid | s_axil_a_rready) & ~rst;
    assign b_rd_en = s_axil_b_arvalid & ~s_axil_b_arready
                   & (~s_axil_b_rvalid | s_axil_b_rready) & ~rst;

    assign s_axil_a_bresp = 2'b00;
    assign s_axil_a_rresp = 2'b00;
    assign s_axil_b_bresp = 2'b00;
    assign s_axil_b_rresp = 2'b00;

    // Port B merges on top of port A's result so overlapping bytes come from B.
    always_comb begin
        a_mask   = strb_mask(s_axil_a_wstrb);
        b_mask   = strb_mask(s_axil_b_wstrb);
        a_merged = (mem[a_wr_word] & ~a_mask) | (s_axil_a_wdata & a_mask);
        b_base   = (a_wr_en && (a_wr_word == b_wr_word)) ? a_merged : mem[b_wr_word];
        b_merged = (b_base & ~b_mask) | (s_axil_b_wdata & b_mask);
    end

    always_ff @(posedge clk) begin
        if (a_wr_en) mem[a_wr_word] <= a_merged;
        if (b_wr_en) mem[b_wr_word] <= b_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_a_awready <= 1'b0;
            s_axil_a_wready  <= 1'b0;
            s_axil_a_bvalid  <= 1'b0;
        end else begin
            s_axil_a_awready <= a_wr_en;
            s_axil_a_wready  <= a_wr_en;
            if (a_wr_en)              s_axil_a_bvalid <= 1'b1;
            else if (s_axil_a_bready) s_axil_a_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_b_awready <= 1'b0;
            s_axil_b_wready  <= 1'b0;
            s_axil_b_bvalid  <= 1'b0;
        end else begin
            s_axil_b_awready <= b_wr_en;
            s_axil_b_wready  <= b_wr_en;
            if (b_wr_en)              s_axil_b_bvalid <= 1'b1;
            else if (s_axil_b_bready) s_axil_b_bvalid <= 1'b0;
        end
    end

    // Reads sample mem before this edge's writes land: read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_a_arready <= 1'b0;
            s_axil_a_rvalid  <= 1'b0;
            s_axil_a_rdata   <= '0;
        end else begin
            s_axil_a_arready <= a_rd_en;
            if (a_rd_en) begin
                s_axil_a_rdata  <= mem[a_rd_word];
                s_axil_a_rvalid <= 1'b1;
            end else if (s_axil_a_rready) begin
                s_axil_a_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_b_arready <= 1'b0;
            s_axil_b_rvalid  <= 1'b0;
            s_axil_b_rdata   <= '0;
        end else begin
            s_axil_b_arready <= b_rd_en;
            if (b_rd_en) begin
                s_axil_b_rdata  <= mem[b_rd_word];
                s_axil_b_rvalid <= 1'b1;
            end else if (s_axil_b_rready) begin
                s_axil_b_rvalid <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axil_a_awprot, s_axil_a_arprot, s_axil_b_awprot,
                         s_axil_b_arprot, s_axil_a_awaddr, s_axil_a_araddr,
                         s_axil_b_awaddr, s_axil_b_araddr};

endmodule

// File: tb/tb_axil_dual_port_ram.sv
// Testbench for axil_dual_port_ram: vector table, hand-written handshake sequences
// and randomized traffic checked against a word-array reference model.
module tb_axil_dual_port_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] awaddr [2];
    logic [2:0]  awprot [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [1:0]  bresp [2];
    logic        bvalid [2];
    logic        bready [2];
    logic [16:0] araddr [2];
    logic [2:0]  arprot [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rvalid [2];
    logic        rready [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    axil_dual_port_ram dut (
        .clk(clk), .rst(rst),
        .s_axil_a_awaddr(awaddr[0]), .s_axil_a_awprot(awprot[0]), .s_axil_a_awvalid(awvalid[0]),
        .s_axil_a_awready(awready[0]), .s_axil_a_wdata(wdata[0]), .s_axil_a_wstrb(wstrb[0]),
        .s_axil_a_wvalid(wvalid[0]), .s_axil_a_wready(wready[0]), .s_axil_a_bresp(bresp[0]),
        .s_axil_a_bvalid(bvalid[0]), .s_axil_a_bready(bready[0]), .s_axil_a_araddr(araddr[0]),
        .s_axil_a_arprot(arprot[0]), .s_axil_a_arvalid(arvalid[0]), .s_axil_a_arready(arready[0]),
        .s_axil_a_rdata(rdata[0]), .s_axil_a_rresp(rresp[0]), .s_axil_a_rvalid(rvalid[0]),
        .s_axil_a_rready(rready[0]),
        .s_axil_b_awaddr(awaddr[1]), .s_axil_b_awprot(awprot[1]), .s_axil_b_awvalid(awvalid[1]),
        .s_axil_b_awready(awready[1]), .s_axil_b_wdata(wdata[1]), .s_axil_b_wstrb(wstrb[1]),
        .s_axil_b_wvalid(wvalid[1]), .s_axil_b_wready(wready[1]), .s_axil_b_bresp(bresp[1]),
        .s_axil_b_bvalid(bvalid[1]), .s_axil_b_bready(bready[1]), .s_axil_b_araddr(araddr[1]),
        .s_axil_b_arprot(arprot[1]), .s_axil_b_arvalid(arvalid[1]), .s_axil_b_arready(arready[1]),
        .s_axil_b_rdata(rdata[1]), .s_axil_b_rresp(rresp[1]), .s_axil_b_rvalid(rvalid[1]),
        .s_axil_b_rready(rready[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_write(input logic [16:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        int w = int'(a[16:2]);
        logic [31:0] cur;
        cur = model.exists(w) ? model[w] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        model[w] = cur;
    endfunction

    function automatic logic [31:0] model_read(input logic [16:0] a);
        int w = int'(a[16:2]);
        return model.exists(w) ? model[w] : 32'hxxxxxxxx;
    endfunction

    task automatic axi_write(input int p, input logic [16:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int n = 0;
        awaddr[p] = a; wdata[p] = d; wstrb[p] = s;
        awvalid[p] = 1'b1; wvalid[p] = 1'b1; bready[p] = 1'b1;
        do begin @(negedge clk); n++; end while (!awready[p] && n < 16);
        chk("wr_awready", {31'b0, awready[p]}, 32'd1);
        chk("wr_wready", {31'b0, wready[p]}, 32'd1);
        chk("wr_bvalid", {31'b0, bvalid[p]}, 32'd1);
        chk("wr_bresp", {30'b0, bresp[p]}, 32'd0);
        awvalid[p] = 1'b0; wvalid[p] = 1'b0;
        @(negedge clk);
        chk("wr_awready_pulse", {31'b0, awready[p]}, 32'd0);
        chk("wr_bvalid_clear", {31'b0, bvalid[p]}, 32'd0);
        model_write(a, d, s);
    endtask

    task automatic axi_read(input int p, input logic [16:0] a, input logic [31:0] exp);
        int n = 0;
        araddr[p] = a; arvalid[p] = 1'b1; rready[p] = 1'b1;
        do begin @(negedge clk); n++; end while (!arready[p] && n < 16);
        chk("rd_arready", {31'b0, arready[p]}, 32'd1);
        chk("rd_rvalid", {31'b0, rvalid[p]}, 32'd1);
        chk("rd_rresp", {30'b0, rresp[p]}, 32'd0);
        chk($sformatf("rd_data_p%0d_%h", p, a), rdata[p], exp);
        arvalid[p] = 1'b0;
        @(negedge clk);
        chk("rd_arready_pulse", {31'b0, arready[p]}, 32'd0);
        chk("rd_rvalid_clear", {31'b0, rvalid[p]}, 32'd0);
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [16:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = '0; awprot[p] = '0; awvalid[p] = 1'b0; wdata[p] = '0; wstrb[p] = '0;
            wvalid[p] = 1'b0; bready[p] = 1'b0; araddr[p] = '0; arprot[p] = '0;
            arvalid[p] = 1'b0; rready[p] = 1'b0;
        end
        vecs[0] = '{1, 1'b1, 17'h00000, 32'h00000013, 4'hF, 32'h0};
        vecs[1] = '{0, 1'b0, 17'h00000, 32'h0,        4'h0, 32'h00000013};
        vecs[2] = '{0, 1'b1, 17'h00104, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[3] = '{0, 1'b0, 17'h00104, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[4] = '{0, 1'b0, 17'h00106, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[5] = '{0, 1'b1, 17'h00200, 32'h11223344, 4'hF, 32'h0};
        vecs[6] = '{0, 1'b1, 17'h00200, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[7] = '{1, 1'b0, 17'h00200, 32'h0,        4'h0, 32'h11BB33DD};
        vecs[8] = '{1, 1'b0, 17'h00203, 32'h0,        4'h0, 32'h11BB33DD};

        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk("rst_awready", {31'b0, awready[p]}, 32'd0);
            chk("rst_wready", {31'b0, wready[p]}, 32'd0);
            chk("rst_bvalid", {31'b0, bvalid[p]}, 32'd0);
            chk("rst_arready", {31'b0, arready[p]}, 32'd0);
            chk("rst_rvalid", {31'b0, rvalid[p]}, 32'd0);
            chk("rst_rdata", rdata[p], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Vector table: preload, full/byte-strobed writes, offset-ignored reads.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].strb);
            else            axi_read(vecs[i].port, vecs[i].addr, vecs[i].exp);
        end

        // Write backpressure: second write must wait for bready.
        awaddr[0] = 17'h300; wdata[0] = 32'h01020304; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
        @(negedge clk);
        chk("bp_w1_awready", {31'b0, awready[0]}, 32'd1);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        model_write(17'h300, 32'h01020304, 4'hF);
        @(negedge clk);
        awaddr[0] = 17'h304; wdata[0] = 32'h05060708;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_w2_blocked", {31'b0, awready[0]}, 32'd0);
            chk("bp_bvalid_hold", {31'b0, bvalid[0]}, 32'd1);
        end
        bready[0] = 1'b1;
        @(negedge clk);
        chk("bp_w2_awready", {31'b0, awready[0]}, 32'd1);
        chk("bp_w2_bvalid", {31'b0, bvalid[0]}, 32'd1);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        model_write(17'h304, 32'h05060708, 4'hF);
        @(negedge clk);
        chk("bp_bvalid_clear", {31'b0, bvalid[0]}, 32'd0);
        axi_read(0, 17'h300, model_read(17'h300));
        axi_read(1, 17'h304, model_read(17'h304));

        // Read backpressure: rdata holds while rready is low.
        araddr[0] = 17'h104; arvalid[0] = 1'b1; rready[0] = 1'b0;
        @(negedge clk);
        chk("bpr_r1_data", rdata[0], 32'hDEADBEEF);
        arvalid[0] = 1'b0;
        @(negedge clk);
        araddr[0] = 17'h000; arvalid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bpr_r2_blocked", {31'b0, arready[0]}, 32'd0);
            chk("bpr_rvalid_hold", {31'b0, rvalid[0]}, 32'd1);
            chk("bpr_rdata_hold", rdata[0], 32'hDEADBEEF);
        end
        rready[0] = 1'b1;
        @(negedge clk);
        chk("bpr_r2_arready", {31'b0, arready[0]}, 32'd1);
        chk("bpr_r2_data", rdata[0], 32'h00000013);
        arvalid[0] = 1'b0;
        @(negedge clk);
        chk("bpr_rvalid_clear", {31'b0, rvalid[0]}, 32'd0);

        // Dual port: B writes the top word while A reads word 0.
        awaddr[1] = 17'h1FFFC; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b1;
        araddr[0] = 17'h0; arvalid[0] = 1'b1; rready[0] = 1'b1;
        @(negedge clk);
        chk("dp_b_awready", {31'b0, awready[1]}, 32'd1);
        chk("dp_a_arready", {31'b0, arready[0]}, 32'd1);
        chk("dp_a_rdata", rdata[0], 32'h00000013);
        awvalid[1] = 1'b0; wvalid[1] = 1'b0; arvalid[0] = 1'b0;
        model_write(17'h1FFFC, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        axi_read(0, 17'h1FFFC, 32'hCAFEF00D);

        // Same-word simultaneous writes: full overlap, then disjoint strobes.
        for (int k = 0; k < 2; k++) begin
            awaddr[0] = 17'h400; awaddr[1] = 17'h400;
            wdata[0] = (k == 0) ? 32'h11111111 : 32'hAAAAAAAA;
            wdata[1] = (k == 0) ? 32'h22222222 : 32'hBBBBBBBB;
            wstrb[0] = (k == 0) ? 4'hF : 4'h3;
            wstrb[1] = (k == 0) ? 4'hF : 4'hC;
            for (int p = 0; p < 2; p++) begin
                awvalid[p] = 1'b1; wvalid[p] = 1'b1; bready[p] = 1'b1;
            end
            @(negedge clk);
            chk("sw_a_awready", {31'b0, awready[0]}, 32'd1);
            chk("sw_b_awready", {31'b0, awready[1]}, 32'd1);
            for (int p = 0; p < 2; p++) begin awvalid[p] = 1'b0; wvalid[p] = 1'b0; end
            @(negedge clk);
            axi_read(0, 17'h400, (k == 0) ? 32'h22222222 : 32'hBBBBAAAA);
        end
        model[int'(17'h400 >> 2)] = 32'hBBBBAAAA;

        // Collision: B reads the word A writes in the same edge and sees the old value.
        awaddr[0] = 17'h400; wdata[0] = 32'h33333333; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
        araddr[1] = 17'h400; arvalid[1] = 1'b1; rready[1] = 1'b1;
        @(negedge clk);
        chk("rbw_old", rdata[1], 32'hBBBBAAAA);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[1] = 1'b0;
        model_write(17'h400, 32'h33333333, 4'hF);
        @(negedge clk);
        axi_read(1, 17'h400, 32'h33333333);

        // Randomized traffic over a small word pool.
        for (int k = 0; k < 8; k++)
            axi_write(int'($urandom_range(0, 1)), 17'h1000 + 17'(4 * k), $urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            int p = int'($urandom_range(0, 1));
            logic [16:0] a;
            a = 17'h1000 + 17'(4 * $urandom_range(0, 7)) + 17'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) axi_write(p, a, $urandom, 4'($urandom));
            else                           axi_read(p, a, model_read(a));
        end

        // Reset with a response pending on each channel.
        awaddr[0] = 17'h500; wdata[0] = 32'h5A5A5A5A; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
        araddr[1] = 17'h104; arvalid[1] = 1'b1; rready[1] = 1'b0;
        @(negedge clk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[1] = 1'b0;
        model_write(17'h500, 32'h5A5A5A5A, 4'hF);
        @(negedge clk);
        chk("mr_bvalid_before", {31'b0, bvalid[0]}, 32'd1);
        chk("mr_rvalid_before", {31'b0, rvalid[1]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_bvalid_async", {31'b0, bvalid[0]}, 32'd0);
        chk("mr_rvalid_async", {31'b0, rvalid[1]}, 32'd0);
        chk("mr_rdata_async", rdata[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axi_read(0, 17'h500, 32'h5A5A5A5A);
        axi_read(1, 17'h104, 32'hDEADBEEF);
        axi_read(0, 17'h1FFFC, model_read(17'h1FFFC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_dual_port_ram.md
Name: axil_dual_port_ram

Overview:
- Dual-port AXI4-Lite slave RAM (ports A and B), both ports on one clock.
- Port A serves the CPU's AXI-Lite memory bus (instruction fetch and data).
- Port B serves an external loader/debug master.
- The storage array is named `mem`, one entry per word, so firmware can be preloaded hierarchically with `$readmemh` into `<inst>.mem`.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 17: byte address width of each port.
- STRB_WIDTH, DATA_WIDTH/8: byte strobe width (derived; do not override).

Ports:
- clk  in  1  single clock for both ports
- rst  in  1  asynchronous reset, active-high
- s_axil_{a,b}_awaddr  in  ADDR_WIDTH  write byte address
- s_axil_{a,b}_awprot  in  3  ignored
- s_axil_{a,b}_awvalid  in  1  write address valid
- s_axil_{a,b}_awready  out  1  write address accepted
- s_axil_{a,b}_wdata  in  DATA_WIDTH  write data
- s_axil_{a,b}_wstrb  in  STRB_WIDTH  byte enables
- s_axil_{a,b}_wvalid  in  1  write data valid
- s_axil_{a,b}_wready  out  1  write data accepted
- s_axil_{a,b}_bresp  out  2  always 2'b00 (OKAY)
- s_axil_{a,b}_bvalid  out  1  write response valid
- s_axil_{a,b}_bready  in  1  write response ready
- s_axil_{a,b}_araddr  in  ADDR_WIDTH  read byte address
- s_axil_{a,b}_arprot  in  3  ignored
- s_axil_{a,b}_arvalid  in  1  read address valid
- s_axil_{a,b}_arready  out  1  read address accepted
- s_axil_{a,b}_rdata  out  DATA_WIDTH  read data
- s_axil_{a,b}_rresp  out  2  always 2'b00
- s_axil_{a,b}_rvalid  out  1  read data valid
- s_axil_{a,b}_rready  in  1  read data ready

Behaviour:
- Memory geometry:
  - `mem` holds 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words of DATA_WIDTH (default 32768 x 32).
  - Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low byte-offset bits are ignored.
  - No out-of-range case exists; all addresses map.
- Reset (async, rst=1):
  - awready, wready, bvalid, arready and rvalid clear to 0 on both ports.
  - rdata clears to 0.
  - `mem` is not cleared.
- Write channel (per port, independent):
  - Accept condition, evaluated each rising edge: awvalid & wvalid & !awready & (!bvalid | bready).
  - When true at edge N:
    - write every byte i with wstrb[i]=1 into mem[word];
    - drive awready=wready=1 for exactly one cycle (registered);
    - set bvalid=1.
  - Master completes the AW/W handshake at edge N+1. awready and wready always assert together.
  - bvalid holds until a cycle with bready=1, then clears at that edge unless a new accept sets it again in the same cycle.
  - The !awready term guarantees back-to-back writes take at least 2 cycles each.
  - awvalid without wvalid (or the reverse) is never accepted.
- Read channel (per port):
  - Accept condition: arvalid & !arready & (!rvalid | rready).
  - When true at edge N: rdata <= mem[word], rvalid <= 1, arready=1 for one cycle.
  - rvalid clears on an rready edge unless re-set by a new accept.
  - rdata is stable while rvalid=1 and rready=0.
- Read/write collision:
  - A read of a word being written in the same edge returns the old value (read-before-write).
  - Ports A and B writing the same word in the same edge: port B's enabled bytes win; non-overlapping strobes merge.
- rst asserted mid-transaction: pending responses are dropped; memory contents already written are kept.

Test Plan:
- Preload mem[0]=32'h00000013 via `$readmemh`; port A read addr 0x0 -> arready pulse one cycle after arvalid, rvalid=1 with rdata=32'h00000013, rresp=0.
- Port A write addr 0x104, wdata=32'hDEADBEEF, wstrb=4'hF, bready=1 -> awready/wready one-cycle pulse, bvalid then cleared; read 0x104 returns 32'hDEADBEEF; read 0x106 also returns it (offset ignored).
- Byte strobes: write 0x200=32'h11223344 (strb F), then 32'hAABBCCDD with strb 4'b0101 -> read returns 32'h11BB33DD.
- Backpressure: hold bready=0 after a write -> bvalid stays 1; a second write is not accepted (awready stays 0) until bready=1. Same check with rready=0 on reads, rdata held constant.
- Dual port: port B writes 0x1FFFC=32'hCAFEF00D while port A reads 0x0 in the same cycle -> both complete; port A then reads 0x1FFFC = 32'hCAFEF00D. Simultaneous A/B writes to the same word with full strobes -> B's data is stored.
- Assert rst while bvalid=1 and rvalid=1 -> both drop immediately (asynchronously); previously written data is still readable after rst deasserts.
